// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the BCD countdown timer.
package bcd_pkg;
  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE    = 4'd9;
  localparam logic [3:0] BCD_ZERO    = 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit: borrow-chained decrement of the live count digit, plus the
// >9 clamp applied to the matching preset digit on load.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  input  logic                   borrow_in,
  output logic [BCD_DIGIT_W-1:0] digit_out,
  output logic                   borrow_out,
  input  logic [BCD_DIGIT_W-1:0] ld_in,
  output logic [BCD_DIGIT_W-1:0] ld_out,
  output logic                   ld_over
);
  always_comb begin
    ld_over    = (ld_in > BCD_NINE);
    ld_out     = ld_over ? BCD_NINE : ld_in;
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == BCD_ZERO) begin
        digit_out  = BCD_NINE;
        borrow_out = 1'b1;
      end else begin
        digit_out  = digit_in - 4'd1;
      end
    end
  end
endmodule

// File: rtl/bcd_countdown.sv
// N-digit BCD countdown timer with load/start/pause control and done pulse.
// Optional auto-reload on reaching zero: define BCD_COUNTDOWN_AUTO_RELOAD_EN.
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 3,
  parameter int TICK_SYNC = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] load_val,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          tick,
  output logic [BCD_DIGIT_W*DIGITS-1:0] count,
  output logic                          running,
  output logic                          zero,
  output logic                          done,
  output logic                          invalid
);
  localparam int CW = BCD_DIGIT_W * DIGITS;

  state_t          r_state, w_nxt_state;
  logic [CW-1:0]   r_count, w_nxt_count, w_dec, w_ld_clean;
  logic [DIGITS:0] w_borrow;
  logic [DIGITS-1:0] w_ld_over;
  logic            r_done, w_nxt_done;
  logic            r_invalid, w_nxt_invalid;
  logic            w_tick_q, w_zero;

  assign w_borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_dec u_dig (
      .digit_in  (r_count[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .borrow_in (w_borrow[g]),
      .digit_out (w_dec[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .borrow_out(w_borrow[g+1]),
      .ld_in     (load_val[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .ld_out    (w_ld_clean[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .ld_over   (w_ld_over[g])
    );
  end

  // Level tick: registered rising-edge strobe, one cycle later than a raw strobe.
  if (TICK_SYNC != 0) begin : g_tsync
    logic r_tick_d, r_tick_p;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_tick_d <= 1'b0;
        r_tick_p <= 1'b0;
      end else begin
        r_tick_d <= tick;
        r_tick_p <= tick & ~r_tick_d;
      end
    end
    assign w_tick_q = r_tick_p;
  end else begin : g_tdirect
    assign w_tick_q = tick;
  end

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  logic [CW-1:0] r_reload;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_reload <= '0;
    else if (load) r_reload <= w_ld_clean;
  end
`endif

  assign w_zero = (r_count == '0);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_count   = r_count;
    w_nxt_done    = 1'b0;
    w_nxt_invalid = r_invalid;
    if (load) begin
      w_nxt_state   = IDLE;
      w_nxt_count   = w_ld_clean;
      w_nxt_invalid = |w_ld_over;
    end else begin
      case (r_state)
        IDLE: begin
          if (!pause && start) begin
            if (w_zero) begin
              w_nxt_state = DONE;
              w_nxt_done  = 1'b1;
            end else begin
              w_nxt_state = RUN;
            end
          end
        end
        RUN: begin
          if (pause) w_nxt_state = PAUSE;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
          // Zero in RUN only follows a reload-armed expiry: restart from the preset.
          else if (w_zero) w_nxt_count = r_reload;
`endif
          else if (!start && w_tick_q && !w_borrow[DIGITS]) begin
            w_nxt_count = w_dec;
            if (w_dec == '0) begin
              w_nxt_done = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
              if (r_reload == '0) w_nxt_state = DONE;
`else
              w_nxt_state = DONE;
`endif
            end
          end
        end
        PAUSE: begin
          if (!pause && start) w_nxt_state = RUN;
        end
        DONE: begin
          if (!pause && start) w_nxt_done = 1'b1;
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_count   <= w_nxt_count;
      r_done    <= w_nxt_done;
      r_invalid <= w_nxt_invalid;
    end
  end

  assign count   = r_count;
  assign zero    = w_zero;
  assign done    = r_done;
  assign invalid = r_invalid;
  assign running = (r_state == RUN);
endmodule

// File: tb/tb_bcd_countdown.sv
// Directed-vector bench for bcd_countdown (DIGITS=3, TICK_SYNC=1).
module tb_bcd_countdown;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         running, zero, done, invalid;

  int n_vec = 0;
  int n_err = 0;

  bcd_countdown #(.DIGITS(3), .TICK_SYNC(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .tick(tick),
    .count(count), .running(running), .zero(zero), .done(done), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v; step(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1; step(); pause = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0; step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic test_reset();
    n_vec++; if ({count, zero, running, done, invalid} !== {12'h000, 4'b1000}) begin n_err++; $display("FAIL reset_state: got %h/%b%b%b%b want 000/1000", count, zero, running, done, invalid); end
    do_load(12'h057); do_start(); do_tick();
    n_vec++; if ({count, running} !== {12'h056, 1'b1}) begin n_err++; $display("FAIL pre_reset_run: got %h run=%b want 056 run=1", count, running); end
    #2; rst_n = 1'b0; #1;
    n_vec++; if ({count, zero, running} !== {12'h000, 1'b1, 1'b0}) begin n_err++; $display("FAIL async_reset: got %h z=%b run=%b want 000 z=1 run=0", count, zero, running); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_countdown();
    do_load(12'h100);
    n_vec++; if ({count, zero} !== {12'h100, 1'b0}) begin n_err++; $display("FAIL load_100: got %h z=%b want 100 z=0", count, zero); end
    do_start();
    n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL start_running: got %b want 1", running); end
    do_tick();
    n_vec++; if (count !== 12'h099) begin n_err++; $display("FAIL borrow_100: got %h want 099", count); end
    ticks(98);
    n_vec++; if ({count, done} !== {12'h001, 1'b0}) begin n_err++; $display("FAIL count_001: got %h done=%b want 001 done=0", count, done); end
    do_tick();
    n_vec++; if ({count, done, running, zero} !== {12'h000, 3'b101}) begin n_err++; $display("FAIL reach_zero: got %h d=%b r=%b z=%b want 000 d=1 r=0 z=1", count, done, running, zero); end
    step();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b want 0", done); end
    ticks(3);
    n_vec++; if ({count, done} !== {12'h000, 1'b0}) begin n_err++; $display("FAIL hold_zero: got %h done=%b want 000 done=0", count, done); end
  endtask

  task automatic test_invalid();
    do_load(12'h3A2);
    n_vec++; if ({count, invalid} !== {12'h392, 1'b1}) begin n_err++; $display("FAIL clamp_3A2: got %h inv=%b want 392 inv=1", count, invalid); end
    do_load(12'hFFF);
    n_vec++; if ({count, invalid} !== {12'h999, 1'b1}) begin n_err++; $display("FAIL clamp_FFF: got %h inv=%b want 999 inv=1", count, invalid); end
    do_load(12'h005);
    n_vec++; if ({count, invalid} !== {12'h005, 1'b0}) begin n_err++; $display("FAIL clear_invalid: got %h inv=%b want 005 inv=0", count, invalid); end
  endtask

  task automatic test_pause();
    do_load(12'h005); do_start(); ticks(2);
    n_vec++; if (count !== 12'h003) begin n_err++; $display("FAIL run_to_003: got %h want 003", count); end
    do_pause();
    n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL paused_running: got %b want 0", running); end
    ticks(5);
    n_vec++; if (count !== 12'h003) begin n_err++; $display("FAIL pause_hold: got %h want 003", count); end
    do_start(); ticks(2);
    n_vec++; if ({count, done} !== {12'h001, 1'b0}) begin n_err++; $display("FAIL resume_001: got %h done=%b want 001 done=0", count, done); end
    do_tick();
    n_vec++; if ({count, done} !== {12'h000, 1'b1}) begin n_err++; $display("FAIL resume_done: got %h done=%b want 000 done=1", count, done); end
  endtask

  task automatic test_load_during_run();
    do_load(12'h010); do_start(); do_tick();
    n_vec++; if (count !== 12'h009) begin n_err++; $display("FAIL borrow_010: got %h want 009", count); end
    tick = 1'b1; step();
    tick = 1'b0; load = 1'b1; load_val = 12'h250; step(); load = 1'b0;
    n_vec++; if ({count, running, done} !== {12'h250, 2'b00}) begin n_err++; $display("FAIL load_beats_tick: got %h r=%b d=%b want 250 r=0 d=0", count, running, done); end
    step();
    n_vec++; if (count !== 12'h250) begin n_err++; $display("FAIL idle_hold: got %h want 250", count); end
  endtask

  task automatic test_level_tick();
    do_load(12'h200); do_start();
    tick = 1'b1; repeat (4) step(); tick = 1'b0; step();
    n_vec++; if (count !== 12'h199) begin n_err++; $display("FAIL level_one_dec: got %h want 199", count); end
    step();
    n_vec++; if (count !== 12'h199) begin n_err++; $display("FAIL level_no_extra: got %h want 199", count); end
  endtask

  task automatic test_start_zero();
    do_load(12'h000);
    n_vec++; if (zero !== 1'b1) begin n_err++; $display("FAIL zero_flag: got %b want 1", zero); end
    do_start();
    n_vec++; if ({done, running} !== 2'b10) begin n_err++; $display("FAIL start_at_zero: got d=%b r=%b want d=1 r=0", done, running); end
    step();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL start_zero_pulse: got %b want 0", done); end
    do_start();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL restart_done: got %b want 1", done); end
    step();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL restart_pulse: got %b want 0", done); end
  endtask

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_reload();
    do_load(12'h002); do_start(); do_tick();
    n_vec++; if (count !== 12'h001) begin n_err++; $display("FAIL reload_001: got %h want 001", count); end
    do_tick();
    n_vec++; if ({count, done, running} !== {12'h000, 2'b11}) begin n_err++; $display("FAIL reload_zero: got %h d=%b r=%b want 000 d=1 r=1", count, done, running); end
    step();
    n_vec++; if ({count, done, running} !== {12'h002, 2'b01}) begin n_err++; $display("FAIL reload_value: got %h d=%b r=%b want 002 d=0 r=1", count, done, running); end
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_invalid();
    test_load_during_run();
    test_level_tick();
    test_start_zero();
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    test_reload();
`else
    test_countdown();
    test_pause();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
